// File: rtl/pb_multibot_pkg.sv
// pb_multibot_pkg: port map, IRQ state type and channel limit for pb_multibot_if
package pb_multibot_pkg;
  localparam int MAX_BOTS = 8;
  localparam logic [7:0] P_BTNS  = 8'h00;
  localparam logic [7:0] P_SWLO  = 8'h01;
  localparam logic [7:0] P_SWHI  = 8'h02;
  localparam logic [7:0] P_BANK  = 8'h03;
  localparam logic [7:0] P_PEND  = 8'h04;
  localparam logic [7:0] P_W1C   = 8'h05;
  localparam logic [7:0] P_MASK  = 8'h06;
  localparam logic [7:0] P_LOCX  = 8'h08;
  localparam logic [7:0] P_RMD   = 8'h0D;
  localparam logic [7:0] P_MOT   = 8'h0E;
  localparam logic [7:0] P_DIG   = 8'h10;
  localparam logic [7:0] P_DP    = 8'h18;
  localparam logic [7:0] P_LEDLO = 8'h19;
  localparam logic [7:0] P_LEDHI = 8'h1A;
  typedef enum logic [1:0] {IRQ_IDLE, IRQ_ASSERT, IRQ_SERVICE} irq_state_t;
endpackage

// File: rtl/pb_multibot_if_if.sv
// pb_multibot_if_if: KCPSM6 port bus (address, data, strobes, interrupt handshake)
interface pb_multibot_if_if;
  logic [7:0] port_id;
  logic [7:0] io_data_in;
  logic [7:0] io_data_out;
  logic       write_strobe;
  logic       k_write_strobe;
  logic       read_strobe;
  logic       interrupt;
  logic       interrupt_ack;
  modport master (output port_id, io_data_in, write_strobe, k_write_strobe, read_strobe, interrupt_ack,
                  input io_data_out, interrupt);
  modport slave  (input port_id, io_data_in, write_strobe, k_write_strobe, read_strobe, interrupt_ack,
                  output io_data_out, interrupt);
endinterface

// File: rtl/pb_multibot_chan.sv
// pb_multibot_chan: one bot channel - status view, motctl register, pending bit
// PB_MULTIBOT_SNAPSHOT_EN: status is shadowed on i_upd instead of passed through live
module pb_multibot_chan (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0][7:0] i_stat,
  input  logic            i_upd,
  input  logic            i_w1c,
  input  logic            i_mot_we,
  input  logic [7:0]      i_mot,
  output logic [5:0][7:0] o_stat,
  output logic [7:0]      o_mot,
  output logic            o_pend
);
  logic [7:0] r_mot;
  logic       r_pend;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_mot  <= '0;
      r_pend <= 1'b0;
    end else begin
      if (i_mot_we) r_mot <= i_mot;
      r_pend <= i_upd | (r_pend & ~i_w1c);
    end
  assign o_mot  = r_mot;
  assign o_pend = r_pend;
`ifdef PB_MULTIBOT_SNAPSHOT_EN
  logic [5:0][7:0] r_shadow;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_shadow <= '0;
    else if (i_upd) r_shadow <= i_stat;
  assign o_stat = r_shadow;
`else
  assign o_stat = i_stat;
`endif
endmodule

// File: rtl/pb_multibot_if.sv
// pb_multibot_if: KCPSM6 port-mapped bridge for NUM_BOTS bots with banked access and masked IRQ
// PB_MULTIBOT_SNAPSHOT_EN: status reads return per-channel shadows captured on upd_sysregs
module pb_multibot_if import pb_multibot_pkg::*; #(
  parameter int NUM_BOTS = 2
) (
  input  logic                  sysclk,
  input  logic                  sysreset,
  pb_multibot_if_if.slave       bus,
  input  logic [5:0]            dbbtns,
  input  logic [15:0]           switches,
  input  logic [8*NUM_BOTS-1:0] locx,
  input  logic [8*NUM_BOTS-1:0] locy,
  input  logic [8*NUM_BOTS-1:0] botinfo,
  input  logic [8*NUM_BOTS-1:0] sensors,
  input  logic [8*NUM_BOTS-1:0] lmdist,
  input  logic [8*NUM_BOTS-1:0] rmdist,
  input  logic [NUM_BOTS-1:0]   upd_sysregs,
  output logic [8*NUM_BOTS-1:0] motctl,
  output logic [39:0]           digits,
  output logic [7:0]            dp,
  output logic [15:0]           leds
);
  logic [2:0]          r_bank;
  logic [NUM_BOTS-1:0] r_mask;
  irq_state_t          r_state, w_next;
  logic [5:0][7:0]     w_stat [MAX_BOTS];
  logic [7:0]          w_mot [MAX_BOTS];
  logic [MAX_BOTS-1:0] w_pend;
  logic [7:0]          w_mask8, w_rd, w_port, w_data;
  logic                w_wr, w_irq_any, w_unused;
  assign w_port    = bus.port_id;
  assign w_data    = bus.io_data_in;
  assign w_wr      = bus.write_strobe;
  assign w_mask8   = 8'(r_mask);
  assign w_irq_any = |(w_pend & w_mask8);
  assign w_unused  = bus.read_strobe;
  // Channels beyond NUM_BOTS read as zero, so out-of-range banks need no extra decode
  genvar i;
  generate
    for (i = 0; i < MAX_BOTS; i++) begin : g_ch
      if (i < NUM_BOTS) begin : g_on
        pb_multibot_chan u_chan (
          .clk      (sysclk),
          .rst      (sysreset),
          .i_stat   ({rmdist[8*i+:8], lmdist[8*i+:8], sensors[8*i+:8], botinfo[8*i+:8], locy[8*i+:8], locx[8*i+:8]}),
          .i_upd    (upd_sysregs[i]),
          .i_w1c    (w_wr && w_port == P_W1C && w_data[i]),
          .i_mot_we (w_wr && w_port == P_MOT && r_bank == 3'(i)),
          .i_mot    (w_data),
          .o_stat   (w_stat[i]),
          .o_mot    (w_mot[i]),
          .o_pend   (w_pend[i])
        );
        assign motctl[8*i+:8] = w_mot[i];
      end else begin : g_off
        assign w_stat[i] = '0;
        assign w_mot[i]  = '0;
        assign w_pend[i] = 1'b0;
      end
    end
  endgenerate
  always_comb begin
    w_rd = 8'h00;
    case (w_port)
      P_BTNS:  w_rd = {2'b00, dbbtns};
      P_SWLO:  w_rd = switches[7:0];
      P_SWHI:  w_rd = switches[15:8];
      P_BANK:  w_rd = {5'b0, r_bank};
      P_PEND:  w_rd = w_pend;
      P_MASK:  w_rd = w_mask8;
      P_MOT:   w_rd = w_mot[r_bank];
      default: w_rd = (w_port >= P_LOCX && w_port <= P_RMD) ? w_stat[r_bank][w_port[2:0]] : 8'h00;
    endcase
  end
  always_ff @(posedge sysclk or posedge sysreset)
    if (sysreset) begin
      bus.io_data_out <= '0;
      r_bank          <= '0;
      r_mask          <= '1;
      digits          <= '0;
      dp              <= '0;
      leds            <= '0;
    end else begin
      bus.io_data_out <= w_rd;
      if (w_wr) begin
        if (w_port == P_BANK) r_bank <= w_data[2:0];
        if (w_port == P_MASK) r_mask <= w_data[NUM_BOTS-1:0];
        if (w_port[7:3] == P_DIG[7:3]) digits[5*w_port[2:0]+:5] <= w_data[4:0];
        if (w_port == P_DP) dp <= w_data;
        if (w_port == P_LEDLO) leds[7:0] <= w_data;
        if (w_port == P_LEDHI) leds[15:8] <= w_data;
      end else if (bus.k_write_strobe) begin
        if (!w_port[3]) digits[5*w_port[2:0]+:5] <= w_data[4:0];
        else if (w_port[2:0] == 3'd0) dp <= w_data;
      end
    end
  always_ff @(posedge sysclk or posedge sysreset)
    if (sysreset) r_state <= IRQ_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IRQ_IDLE:    w_next = w_irq_any ? IRQ_ASSERT : IRQ_IDLE;
      IRQ_ASSERT:  w_next = bus.interrupt_ack ? IRQ_SERVICE : (w_irq_any ? IRQ_ASSERT : IRQ_IDLE);
      IRQ_SERVICE: w_next = w_irq_any ? IRQ_SERVICE : IRQ_IDLE;
      default:     w_next = IRQ_IDLE;
    endcase
  end
  assign bus.interrupt = r_state == IRQ_ASSERT;
endmodule

// File: tb/tb_pb_multibot_if.sv
// tb_pb_multibot_if: randomized scoreboard bench for pb_multibot_if against a behavioural port-map model
module tb_pb_multibot_if;
  localparam int NB = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pb_multibot_if_if bus ();
  logic [5:0]      dbbtns;
  logic [15:0]     switches;
  logic [8*NB-1:0] locx, locy, botinfo, sensors, lmdist, rmdist, motctl;
  logic [NB-1:0]   upd;
  logic [39:0]     digits;
  logic [7:0]      dp;
  logic [15:0]     leds;
  pb_multibot_if #(.NUM_BOTS(NB)) dut (
    .sysclk(clk), .sysreset(rst), .bus(bus), .dbbtns(dbbtns), .switches(switches),
    .locx(locx), .locy(locy), .botinfo(botinfo), .sensors(sensors), .lmdist(lmdist), .rmdist(rmdist),
    .upd_sysregs(upd), .motctl(motctl), .digits(digits), .dp(dp), .leds(leds)
  );
  int checks = 0;
  int errors = 0;
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference state: pending/mask as integer bitsets, irq phase 0=quiet 1=requesting 2=being serviced
  int         m_pend, m_mask, m_bank, m_irq;
  logic [7:0] m_mot [8];
  logic [4:0] m_dig [8];
  logic [7:0] m_dp;
  logic [15:0] m_leds;
  logic [7:0] m_shadow [8][6];
  logic [7:0] exp_q [$];
  logic       rd_d;
  function automatic logic [7:0] field(int k, int b);
    logic [8*NB-1:0] v;
    v = k == 0 ? locx : k == 1 ? locy : k == 2 ? botinfo : k == 3 ? sensors : k == 4 ? lmdist : rmdist;
    return v[8*b+:8];
  endfunction
  function automatic logic [7:0] model_read(int a);
    if (a == 0) return {2'b00, dbbtns};
    if (a == 1) return switches[7:0];
    if (a == 2) return switches[15:8];
    if (a == 3) return 8'(m_bank);
    if (a == 4) return 8'(m_pend);
    if (a == 6) return 8'(m_mask);
    if (a == 14) return m_bank < NB ? m_mot[m_bank] : 8'h00;
    if (a >= 8 && a <= 13) begin
      if (m_bank >= NB) return 8'h00;
`ifdef PB_MULTIBOT_SNAPSHOT_EN
      return m_shadow[m_bank][a-8];
`else
      return field(a - 8, m_bank);
`endif
    end
    return 8'h00;
  endfunction
  function automatic logic [39:0] exp_digits();
    logic [39:0] e;
    for (int i = 0; i < 8; i++) e[5*i+:5] = m_dig[i];
    return e;
  endfunction
  function automatic logic [8*NB-1:0] exp_mot();
    logic [8*NB-1:0] e;
    for (int i = 0; i < NB; i++) e[8*i+:8] = m_mot[i];
    return e;
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend <= 0; m_mask <= (1 << NB) - 1; m_bank <= 0; m_irq <= 0;
      m_dp <= 8'h00; m_leds <= 16'h0000; rd_d <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        m_mot[i] <= 8'h00;
        m_dig[i] <= 5'h00;
        for (int k = 0; k < 6; k++) m_shadow[i][k] <= 8'h00;
      end
      exp_q.delete();
    end else begin
      automatic int a = int'(bus.port_id);
      automatic int d = int'(bus.io_data_in);
      automatic int live = m_pend & m_mask;
      automatic int clr = (bus.write_strobe && a == 5) ? d : 0;
      rd_d <= bus.read_strobe;
      if (bus.read_strobe) exp_q.push_back(model_read(a));
      m_pend <= (m_pend & ~clr) | int'(upd);
      if (m_irq == 0 && live != 0) m_irq <= 1;
      else if (m_irq == 1 && bus.interrupt_ack) m_irq <= 2;
      else if (m_irq != 0 && live == 0) m_irq <= 0;
      for (int i = 0; i < NB; i++)
        if (upd[i]) for (int k = 0; k < 6; k++) m_shadow[i][k] <= field(k, i);
      if (bus.write_strobe) begin
        if (a == 3) m_bank <= d & 7;
        if (a == 6) m_mask <= d & ((1 << NB) - 1);
        if (a == 14 && m_bank < NB) m_mot[m_bank] <= 8'(d);
        if (a >= 16 && a <= 23) m_dig[a-16] <= 5'(d);
        if (a == 24) m_dp <= 8'(d);
        if (a == 25) m_leds[7:0] <= 8'(d);
        if (a == 26) m_leds[15:8] <= 8'(d);
      end else if (bus.k_write_strobe) begin
        if ((a & 15) < 8) m_dig[a & 7] <= 5'(d);
        else if ((a & 15) == 8) m_dp <= 8'(d);
      end
    end
  end
  always @(negedge clk) if (!rst) begin
    check("interrupt", bus.interrupt, m_irq == 1);
    check("motctl", motctl, exp_mot());
    check("digits", digits, exp_digits());
    check("dp", dp, m_dp);
    check("leds", leds, m_leds);
    if (rd_d) begin
      if (exp_q.size() == 0) check("rdata_queue_empty", 1, 0);
      else check("rdata", bus.io_data_out, exp_q.pop_front());
    end
  end
  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(logic [7:0] a, logic [7:0] d, bit k = 0);
    @(posedge clk); #1;
    bus.port_id = a; bus.io_data_in = d;
    if (k) bus.k_write_strobe = 1'b1; else bus.write_strobe = 1'b1;
    @(posedge clk); #1;
    bus.write_strobe = 1'b0; bus.k_write_strobe = 1'b0;
  endtask
  task automatic rd(logic [7:0] a);
    @(posedge clk); #1;
    bus.port_id = a; bus.read_strobe = 1'b1;
    @(posedge clk); #1;
    bus.read_strobe = 1'b0;
  endtask
  task automatic pulse(logic [NB-1:0] m);
    @(posedge clk); #1 upd = m;
    @(posedge clk); #1 upd = '0;
  endtask
  task automatic ack();
    @(posedge clk); #1 bus.interrupt_ack = 1'b1;
    @(posedge clk); #1 bus.interrupt_ack = 1'b0;
  endtask
  initial begin
    bus.port_id = 8'h00; bus.io_data_in = 8'h00;
    bus.write_strobe = 1'b0; bus.k_write_strobe = 1'b0; bus.read_strobe = 1'b0; bus.interrupt_ack = 1'b0;
    dbbtns = '0; switches = '0; upd = '0;
    locx = '0; locy = '0; botinfo = '0; sensors = '0; lmdist = '0; rmdist = '0;
    idle(3);
    @(negedge clk);
    check("rst_interrupt", bus.interrupt, 0);
    check("rst_outputs", {motctl, dp, leds}, 0);
    check("rst_digits", digits, 0);
    check("rst_rdata", bus.io_data_out, 0);
    idle(1); rst = 1'b0;
    rd(8'h06);
    @(negedge clk) check("mask_reset_read", bus.io_data_out, 8'h03);
    locx = 16'h5A00;
    pulse(2'b10);
    wr(8'h03, 8'h01);
    rd(8'h08);
    @(negedge clk) check("bank1_locx", bus.io_data_out, 8'h5A);
    wr(8'h03, 8'h03);
    rd(8'h08);
    @(negedge clk) check("bank3_locx", bus.io_data_out, 8'h00);
    wr(8'h05, 8'h03);
    wr(8'h03, 8'h00);
    idle(2);
    @(posedge clk); #1 upd = 2'b01;
    @(posedge clk); #1 upd = '0;
    @(negedge clk) check("irq_t1", bus.interrupt, 0);
    @(posedge clk);
    @(negedge clk) check("irq_t2", bus.interrupt, 1);
    ack();
    @(negedge clk) check("irq_after_ack", bus.interrupt, 0);
    wr(8'h05, 8'h01);
    rd(8'h04);
    @(negedge clk) check("pending_cleared", bus.io_data_out, 8'h00);
    wr(8'h06, 8'h02);
    pulse(2'b01);
    idle(3);
    @(negedge clk) check("masked_no_irq", bus.interrupt, 0);
    wr(8'h06, 8'h03);
    @(posedge clk);
    @(negedge clk) check("unmask_irq", bus.interrupt, 1);
    ack();
    wr(8'h05, 8'h01);
    @(posedge clk); #1;
    upd = 2'b01; bus.port_id = 8'h05; bus.io_data_in = 8'h01; bus.write_strobe = 1'b1;
    @(posedge clk); #1;
    upd = '0; bus.write_strobe = 1'b0;
    rd(8'h04);
    @(negedge clk) check("set_beats_w1c", bus.io_data_out, 8'h01);
    ack();
    wr(8'h05, 8'h01);
    wr(8'h03, 8'h11, 1);
    @(negedge clk) check("kwrite_dig3", digits[19:15], 5'h11);
    wr(8'h0E, 8'h84);
    @(negedge clk) check("motctl0", motctl[7:0], 8'h84);
    wr(8'h03, 8'h03);
    wr(8'h0E, 8'hFF);
    @(negedge clk) check("motctl_bank3_dropped", motctl, 16'h0084);
    @(posedge clk); #2 rst = 1'b1;
    #1 check("async_rst_outs", {motctl, dp, leds, bus.interrupt, bus.io_data_out}, 0);
    check("async_rst_digits", digits, 0);
    idle(2); rst = 1'b0;
    repeat (600) begin
      @(posedge clk); #1;
      bus.write_strobe = 1'b0; bus.k_write_strobe = 1'b0;
      case ($urandom_range(0, 3))
        0: bus.write_strobe = 1'b1;
        1: bus.k_write_strobe = 1'b1;
        default: ;
      endcase
      bus.port_id = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
      bus.io_data_in = 8'($urandom);
      bus.read_strobe = $urandom_range(0, 2) == 0;
      bus.interrupt_ack = $urandom_range(0, 5) == 0;
      upd = ($urandom_range(0, 5) == 0) ? NB'($urandom) : '0;
      dbbtns = 6'($urandom); switches = 16'($urandom);
      locx = (8*NB)'($urandom); locy = (8*NB)'($urandom); botinfo = (8*NB)'($urandom);
      sensors = (8*NB)'($urandom); lmdist = (8*NB)'($urandom); rmdist = (8*NB)'($urandom);
    end
    @(posedge clk); #1;
    bus.write_strobe = 1'b0; bus.k_write_strobe = 1'b0; bus.read_strobe = 1'b0;
    bus.interrupt_ack = 1'b0; upd = '0;
    idle(3);
    check("rdata_queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
